// File: rtl/ram_scan_pkg.sv
// Shared types and default widths for the RAM scan reader.
package ram_scan_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/ram_scan_reader_tick_prescaler.sv
// Free-running prescaler: one-clock tick every TICK_CNT clocks.
module tick_prescaler #(
    parameter int unsigned TICK_CNT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sequencer: walks the RAM read port, captures each word for display,
// and keeps the displayed word coherent with snooped same-address writes.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned TICK_CNT = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              step,
    input  logic [DATA_W-1:0] q,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] rdaddress,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic              dvalid_q, dvalid_d;
    logic              byp_q, byp_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic              step_q;

    logic tick;
    logic step_rise;
    logic advance;
    logic wr_rd_hit;
    logic wr_disp_hit;

    tick_prescaler #(
        .TICK_CNT (TICK_CNT)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign step_rise   = step & ~step_q;
    assign advance     = (tick & ~pause) | (step_rise & pause);
    assign wr_rd_hit   = wren && (wraddress == rdaddr_q);
    assign wr_disp_hit = wren && (wraddress == daddr_q);

    // Next-state and register updates for the scan FSM, bypass and display path.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rdaddr_d   = rdaddr_q;
        daddr_d    = daddr_q;
        ddata_d    = ddata_q;
        dvalid_d   = 1'b0;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;

        case (state_q)
            ST_WAIT: begin
                if (wr_rd_hit) begin
                    byp_data_d = wdata;
                    byp_d      = 1'b1;
                end
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CAPTURE: begin
                // A write landing in this very cycle beats both RAM data and the bypass.
                daddr_d  = rdaddr_q;
                ddata_d  = wr_rd_hit ? wdata : (byp_q ? byp_data_q : q);
                dvalid_d = 1'b1;
                byp_d    = 1'b0;
                wait_d   = 2'd0;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (advance) begin
                    rdaddr_d = rdaddr_q + ADDR_W'(1);
                    state_d  = ST_WAIT;
                end else if (wr_disp_hit) begin
                    ddata_d  = wdata;
                    dvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT;
            wait_q     <= 2'd0;
            rdaddr_q   <= '0;
            daddr_q    <= '0;
            ddata_q    <= '0;
            dvalid_q   <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rdaddr_q   <= rdaddr_d;
            daddr_q    <= daddr_d;
            ddata_q    <= ddata_d;
            dvalid_q   <= dvalid_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            step_q     <= step;
        end
    end

    assign rdaddress  = rdaddr_q;
    assign disp_addr  = daddr_q;
    assign disp_data  = ddata_q;
    assign disp_valid = dvalid_q;
    assign busy       = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a 2-clock-latency behavioural RAM.
module tb_ram_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause;
    logic       step;
    logic [2:0] q;
    logic       wren;
    logic [4:0] wraddress;
    logic [2:0] wdata;
    logic [4:0] rdaddress;
    logic [4:0] disp_addr;
    logic [2:0] disp_data;
    logic       disp_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] mem [32];
    logic [2:0] q1;

    always #5 clk = ~clk;

    ram_scan_reader #(
        .ADDR_W   (5),
        .DATA_W   (3),
        .RD_LAT   (2),
        .TICK_CNT (8)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .pause      (pause),
        .step       (step),
        .q          (q),
        .wren       (wren),
        .wraddress  (wraddress),
        .wdata      (wdata),
        .rdaddress  (rdaddress),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    function automatic logic [2:0] init_val(input int i);
        if (i == 7) return 3'd1;
        return 3'(i * 3 + 5);
    endfunction

    // RAM contents are reloaded while reset is held so every run starts from known data.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (wren) begin
            mem[wraddress] <= wdata;
        end
        q1 <= mem[rdaddress];
        q  <= q1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            cyc();
            n++;
            if (disp_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_rdaddr(input logic [4:0] a, input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            cyc();
            if (rdaddress == a) ok = 1'b1;
        end
    endtask

    initial begin
        int   n;
        int   cnt;
        logic ok;

        rst_n = 1'b0;
        pause = 1'b0;
        step = 1'b0;
        wren = 1'b0;
        wraddress = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_rdaddress", 32'(rdaddress), 0);
        check("rst_disp_addr", 32'(disp_addr), 0);
        check("rst_disp_data", 32'(disp_data), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        rst_n = 1'b1;

        // First capture three clocks after reset release.
        wait_valid(10, n, ok);
        check("t1_valid_seen", 32'(ok), 1);
        check("t1_latency", 32'(n), 3);
        check("t1_disp_addr", 32'(disp_addr), 0);
        check("t1_disp_data", 32'(disp_data), 5);

        // Free run: one capture every 8 clocks, wrapping after 31.
        for (int s = 1; s <= 32; s++) begin
            wait_valid(12, n, ok);
            check($sformatf("t2_valid_seen[%0d]", s), 32'(ok), 1);
            check($sformatf("t2_period[%0d]", s), 32'(n), 8);
            check($sformatf("t2_disp_addr[%0d]", s), 32'(disp_addr), 32'(s % 32));
            check($sformatf("t2_disp_data[%0d]", s), 32'(disp_data), 32'(init_val(s % 32)));
        end
        check("t2_busy_hold", 32'(busy), 0);

        // Step edge while running is dropped.
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("t5_step_unpaused[%0d]", i), 32'(rdaddress), 0);
        end
        step = 1'b0;

        // Write to the word being read, one clock after the address change.
        wait_rdaddr(5'd7, 200, ok);
        check("t3_reach_addr7", 32'(ok), 1);
        wren = 1'b1;
        wraddress = 5'd7;
        wdata = 3'd6;
        cyc();
        wren = 1'b0;
        wait_valid(6, n, ok);
        check("t3_valid_seen", 32'(ok), 1);
        check("t3_latency", 32'(n), 2);
        check("t3_disp_addr", 32'(disp_addr), 7);
        check("t3_disp_data", 32'(disp_data), 6);

        // Paused: ticks ignored; a long step pulse advances exactly once.
        pause = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (disp_valid) cnt++;
        end
        check("t5_pause_pulses", 32'(cnt), 0);
        check("t5_pause_rdaddr", 32'(rdaddress), 7);
        cnt = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) step = 1'b0;
            cyc();
            if (disp_valid) cnt++;
        end
        check("t5_step_pulses", 32'(cnt), 1);
        check("t5_step_rdaddr", 32'(rdaddress), 8);
        check("t5_step_disp_addr", 32'(disp_addr), 8);
        check("t5_step_disp_data", 32'(disp_data), 32'(init_val(8)));

        // Asynchronous reset in the middle of a read.
        pause = 1'b0;
        wait_rdaddr(5'd12, 100, ok);
        check("t6_reach_addr12", 32'(ok), 1);
        check("t6_busy_wait", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rdaddress", 32'(rdaddress), 0);
        check("t6_disp_addr", 32'(disp_addr), 0);
        check("t6_disp_data", 32'(disp_data), 0);
        check("t6_disp_valid", 32'(disp_valid), 0);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(10, n, ok);
        check("t6_restart_valid", 32'(ok), 1);
        check("t6_restart_latency", 32'(n), 3);
        check("t6_restart_addr", 32'(disp_addr), 0);
        check("t6_restart_data", 32'(disp_data), 5);

        // Single-step to address 3.
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            wait_valid(8, n, ok);
            check($sformatf("t4_step_latency[%0d]", k), 32'(n), 3);
            check($sformatf("t4_step_addr[%0d]", k), 32'(disp_addr), 32'(k));
            check($sformatf("t4_step_data[%0d]", k), 32'(disp_data), 32'(init_val(k)));
        end

        // Write to the displayed word updates it; other addresses do not.
        wren = 1'b1;
        wraddress = 5'd3;
        wdata = 3'd4;
        cyc();
        wren = 1'b0;
        check("t4_hit_valid", 32'(disp_valid), 1);
        check("t4_hit_data", 32'(disp_data), 4);
        check("t4_hit_addr", 32'(disp_addr), 3);
        cyc();
        check("t4_hit_single_pulse", 32'(disp_valid), 0);
        wren = 1'b1;
        wraddress = 5'd9;
        wdata = 3'd7;
        cyc();
        wren = 1'b0;
        check("t4_miss_valid", 32'(disp_valid), 0);
        check("t4_miss_data", 32'(disp_data), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
